sar_converter_ctrl: RTL and testbench

SAR_CONVERTER_CTRL -- requirements
Module: sar_converter_ctrl

---
 rtl/sar_converter_ctrl_pkg.sv | 17 +
 rtl/sar_converter_ctrl.sv | 112 +++++++++++
 tb/tb_sar_converter_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/sar_converter_ctrl_pkg.sv
// Shared SAR definitions: phase encodings common to the converter and conversion timer,
// plus a counter-sizing helper.
package sar_converter_ctrl_pkg;

  typedef enum logic [1:0] {
    PH_IDLE    = 2'b00,
    PH_SAMPLE  = 2'b01,
    PH_CONVERT = 2'b10,
    PH_DONE    = 2'b11
  } sarPhaseT;

  // Bits needed to hold 0..maxVal, never less than one.
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/sar_converter_ctrl.sv
// SAR conversion controller: sample, binary-search convert, done pulse; single-step DAC tracking in idle.
// Done rises SAMPLE_CYCLES+NBITS+1 cycles after the Start edge; Start while busy is dropped, never queued.
module sar_converter_ctrl
  import sar_converter_ctrl_pkg::*;
#(
  parameter int NBITS         = 8,
  parameter int SAMPLE_CYCLES = 4
) (
  input  logic             ClockT,
  input  logic             Reset,
  input  logic             Start,
  input  logic             TrackEn,
  input  logic             CompIn,
  output logic [1:0]       StateP,
  output logic             Inc,
  output logic             Dcr,
  output logic [NBITS-1:0] DacCode,
  output logic [NBITS-1:0] Result,
  output logic             Done,
  output logic             Busy
);

  localparam int SW = cntWidth(SAMPLE_CYCLES - 1);
  localparam int BW = cntWidth(NBITS - 1);
  localparam logic [SW-1:0]    SampleLast = SW'(SAMPLE_CYCLES - 1);
  localparam logic [BW-1:0]    LastIdx    = BW'(NBITS - 1);
  localparam logic [NBITS-1:0] MsbCode    = {1'b1, {(NBITS-1){1'b0}}};

  sarPhaseT         state, stateNxt;
  logic [SW-1:0]    sampleCnt, sampleCntNxt;
  logic [BW-1:0]    bitIdx, bitIdxNxt;
  logic [NBITS-1:0] dacNxt, resultNxt;
  logic             incNxt, dcrNxt, doneNxt;

  assign StateP = state;
  assign Busy   = (state != PH_IDLE);

  always_ff @(posedge ClockT) begin
    if (Reset) begin
      state     <= PH_IDLE;
      sampleCnt <= '0;
      bitIdx    <= '0;
      DacCode   <= '0;
      Result    <= '0;
      Inc       <= 1'b0;
      Dcr       <= 1'b0;
      Done      <= 1'b0;
    end else begin
      state     <= stateNxt;
      sampleCnt <= sampleCntNxt;
      bitIdx    <= bitIdxNxt;
      DacCode   <= dacNxt;
      Result    <= resultNxt;
      Inc       <= incNxt;
      Dcr       <= dcrNxt;
      Done      <= doneNxt;
    end
  end

  always_comb begin
    stateNxt     = state;
    sampleCntNxt = sampleCnt;
    bitIdxNxt    = bitIdx;
    dacNxt       = DacCode;
    resultNxt    = Result;
    incNxt       = 1'b0;
    dcrNxt       = 1'b0;
    doneNxt      = 1'b0;
    case (state)
      PH_IDLE: begin
        // Start wins over tracking; tracking saturates at both ends.
        if (Start) begin
          stateNxt     = PH_SAMPLE;
          sampleCntNxt = '0;
        end else if (TrackEn) begin
          if (CompIn) begin
            if (!(&DacCode)) begin
              dacNxt = DacCode + 1'b1;
              incNxt = 1'b1;
            end
          end else if (|DacCode) begin
            dacNxt = DacCode - 1'b1;
            dcrNxt = 1'b1;
          end
        end
      end
      PH_SAMPLE: begin
        if (sampleCnt == SampleLast) begin
          stateNxt  = PH_CONVERT;
          dacNxt    = MsbCode;
          bitIdxNxt = LastIdx;
        end else begin
          sampleCntNxt = sampleCnt + 1'b1;
        end
      end
      PH_CONVERT: begin
        if (!CompIn) dacNxt[bitIdx] = 1'b0;
        if (bitIdx != '0) begin
          dacNxt[bitIdx - 1'b1] = 1'b1;
          bitIdxNxt = bitIdx - 1'b1;
        end else begin
          stateNxt  = PH_DONE;
          resultNxt = dacNxt;
          doneNxt   = 1'b1;
        end
      end
      PH_DONE: stateNxt = PH_IDLE;
      default: stateNxt = PH_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sar_converter_ctrl.sv
// Directed bench for sar_converter_ctrl (NBITS=8, SAMPLE_CYCLES=2) with an ideal comparator model.
module tb_sar_converter_ctrl;

  logic       ClockT = 1'b0;
  logic       Reset, Start, TrackEn, CompIn;
  logic [1:0] StateP;
  logic       Inc, Dcr, Done, Busy;
  logic [7:0] DacCode, Result;
  logic [7:0] vin;
  logic       ovrEn, ovrVal;
  int         checks = 0;
  int         errors = 0;

  sar_converter_ctrl #(.NBITS(8), .SAMPLE_CYCLES(2)) dut (
    .ClockT(ClockT), .Reset(Reset), .Start(Start), .TrackEn(TrackEn), .CompIn(CompIn),
    .StateP(StateP), .Inc(Inc), .Dcr(Dcr), .DacCode(DacCode), .Result(Result),
    .Done(Done), .Busy(Busy)
  );

  always #5 ClockT = ~ClockT;

  assign CompIn = ovrEn ? ovrVal : (vin >= DacCode);

  task automatic step();
    @(posedge ClockT);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full conversion; Start optionally held high for the whole run.
  task automatic runConv(input logic [7:0] v, input logic [7:0] expRes,
                         input logic [7:0] dac0, input logic hold);
    logic [1:0] expPh;
    vin   = v;
    Start = 1'b1;
    step();
    Start = hold;
    for (int k = 1; k <= 11; k++) begin
      expPh = (k <= 2) ? 2'b01 : (k <= 10) ? 2'b10 : 2'b11;
      chk($sformatf("phase_%0h_c%0d", v, k), StateP, expPh);
      chk($sformatf("done_%0h_c%0d", v, k), Done, (k == 11));
      chk($sformatf("busy_%0h_c%0d", v, k), Busy, 1'b1);
      chk($sformatf("incdcr_%0h_c%0d", v, k), {Inc, Dcr}, 2'b00);
      if (k == 1) chk($sformatf("dac_sample_%0h", v), DacCode, dac0);
      if (k == 3) chk($sformatf("dac_first_%0h", v), DacCode, 8'h80);
      if (k == 11) begin
        chk($sformatf("result_%0h", v), Result, expRes);
        chk($sformatf("dac_final_%0h", v), DacCode, expRes);
      end
      step();
    end
    chk($sformatf("idle_after_%0h", v), StateP, 2'b00);
    chk($sformatf("done_low_after_%0h", v), Done, 1'b0);
  endtask

  logic [7:0] trkDac [7];
  logic [1:0] trkPulse [7];

  initial begin
    trkDac   = '{8'hA6, 8'hA7, 8'hA8, 8'hA9, 8'hA8, 8'hA9, 8'hA8};
    trkPulse = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01};
    Reset = 1'b1; Start = 1'b0; TrackEn = 1'b0; vin = 8'h00; ovrEn = 1'b0; ovrVal = 1'b0;
    step();
    step();
    chk("rst_state", StateP, 2'b00);
    chk("rst_dac", DacCode, 8'h00);
    chk("rst_result", Result, 8'h00);
    chk("rst_pulses", {Inc, Dcr, Done}, 3'b000);
    chk("rst_busy", Busy, 1'b0);
    Reset = 1'b0;
    step();

    runConv(8'hA5, 8'hA5, 8'h00, 1'b0);

    // Track up to the input then dither around it.
    vin = 8'hA8;
    TrackEn = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("trk_dac_%0d", i), DacCode, trkDac[i]);
      chk($sformatf("trk_pulse_%0d", i), {Inc, Dcr}, trkPulse[i]);
      chk($sformatf("trk_state_%0d", i), StateP, 2'b00);
    end
    TrackEn = 1'b0;

    // Start held through a conversion: one Done, next run only after idle.
    runConv(8'h00, 8'h00, 8'hA8, 1'b1);
    chk("hold_idle_busy", Busy, 1'b0);
    vin = 8'hFF;
    step();
    chk("hold_restart_phase", StateP, 2'b01);
    Start = 1'b0;
    for (int k = 2; k <= 11; k++) begin
      step();
      chk($sformatf("hold2_done_c%0d", k), Done, (k == 11));
    end
    chk("hold2_result", Result, 8'hFF);
    step();
    chk("hold2_idle", StateP, 2'b00);

    // Upper tracking bound.
    TrackEn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("top_dac_%0d", i), DacCode, 8'hFF);
      chk($sformatf("top_pulse_%0d", i), {Inc, Dcr}, 2'b00);
    end
    TrackEn = 1'b0;

    // Reset in CONVERT with bit index 4 pending.
    vin = 8'hA5;
    Start = 1'b1;
    step();
    Start = 1'b0;
    for (int k = 2; k <= 6; k++) step();
    chk("abort_phase", StateP, 2'b10);
    chk("abort_dac_mid", DacCode, 8'hB0);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("abort_state", StateP, 2'b00);
    chk("abort_dac", DacCode, 8'h00);
    chk("abort_result", Result, 8'h00);
    chk("abort_done", Done, 1'b0);
    chk("abort_busy", Busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("abort_nodone_%0d", i), Done, 1'b0);
      chk($sformatf("abort_hold_result_%0d", i), Result, 8'h00);
    end

    // Lower tracking bound.
    ovrEn = 1'b1;
    ovrVal = 1'b0;
    TrackEn = 1'b1;
    step();
    chk("bot_dac", DacCode, 8'h00);
    chk("bot_pulse", {Inc, Dcr}, 2'b00);
    ovrEn = 1'b0;

    // Start beats tracking (TrackEn still high), then a normal conversion.
    runConv(8'h3C, 8'h3C, 8'h00, 1'b0);
    TrackEn = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
